// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared core constants for the fetch front end
// Holds the canonical NOP encoding and the default reset PC so decode and
// pipeline-register logic agree with the fetch queue on both values.
package fetch_queue_pkg;

    // addi x0, x0, 0 -- presented on the decode side whenever nothing is queued
    localparam logic [31:0] NOP_INSTR        = 32'h00000013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h01000000;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - fetched-instruction storage queue with flush
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   flush              drop every queued entry at this edge
//   push, push_data    write an entry at the tail (ignored when full)
//   pop                retire the head entry (ignored when empty)
//   head_data          current head entry, taken straight from the storage flops
//   head_valid         queue holds at least one entry
//   count              number of queued entries, 0..DEPTH
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push    = push && (count != FULL_COUNT);
    assign do_pop     = pop && (count != '0);
    assign head_data  = mem[rd_ptr];
    assign head_valid = (count != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; stale slots are unreachable once the pointers clear.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch PC generator with latency-tracked decode queue
// Ports:
//   clock, reset                   rising-edge clock, synchronous active-high reset
//   imem_address, imem_enable      fetch request to instruction memory
//   imem_data                      instruction returned MEM_LAT cycles after its request
//   redirect_valid, redirect_pc    taken branch/jump: flush everything, refetch from redirect_pc
//   dec_valid, dec_instr, dec_pc   head entry offered to decode
//   dec_ready                      decode consumes the head this cycle
//   occupancy                      number of queued entries
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                DATAW     = 32,
    parameter logic [DATAW-1:0]  BASE_ADDR = DATAW'(RESET_PC_DEFAULT),
    parameter int                DEPTH     = 4,
    parameter int                MEM_LAT   = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [DATAW-1:0]         imem_address,
    output logic                     imem_enable,
    input  logic [DATAW-1:0]         imem_data,
    input  logic                     redirect_valid,
    input  logic [DATAW-1:0]         redirect_pc,
    input  logic                     dec_ready,
    output logic                     dec_valid,
    output logic [DATAW-1:0]         dec_instr,
    output logic [DATAW-1:0]         dec_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATAW-1:0]   fetch_pc;
    logic               tag_valid [MEM_LAT];
    logic [DATAW-1:0]   tag_pc    [MEM_LAT];
    logic [CW-1:0]      inflight;
    logic [CW:0]        committed;
    logic               push;
    logic               pop;
    logic [2*DATAW-1:0] head_data;
    logic               head_valid;

    // Every valid tag, including the one returning this cycle, already owns a
    // queue slot, so requests are only issued while a free slot remains.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + CW'(tag_valid[i]);
        end
    end

    assign committed    = {1'b0, occupancy} + {1'b0, inflight};
    assign imem_address = fetch_pc;
    assign imem_enable  = !reset && !redirect_valid && (committed < (CW + 1)'(DEPTH));

    // A redirect overrides any return or pop landing on the same edge.
    assign push = tag_valid[MEM_LAT-1] && !redirect_valid;
    assign pop  = dec_valid && dec_ready && !redirect_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= BASE_ADDR;
            for (int i = 0; i < MEM_LAT; i++) tag_valid[i] <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~DATAW'(3);
            for (int i = 0; i < MEM_LAT; i++) tag_valid[i] <= 1'b0;
        end else begin
            if (imem_enable) fetch_pc <= fetch_pc + DATAW'(4);
            tag_valid[0] <= imem_enable;
            for (int i = 1; i < MEM_LAT; i++) tag_valid[i] <= tag_valid[i-1];
        end
    end

    // PCs ride alongside the valid bits; they are only consumed when valid.
    always_ff @(posedge clock) begin
        tag_pc[0] <= fetch_pc;
        for (int i = 1; i < MEM_LAT; i++) tag_pc[i] <= tag_pc[i-1];
    end

    fetch_fifo #(
        .WIDTH (2 * DATAW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .push_data  ({tag_pc[MEM_LAT-1], imem_data}),
        .pop        (pop),
        .head_data  (head_data),
        .head_valid (head_valid),
        .count      (occupancy)
    );

    assign dec_valid = head_valid;
    assign dec_instr = head_valid ? head_data[DATAW-1:0]       : DATAW'(NOP_INSTR);
    assign dec_pc    = head_valid ? head_data[2*DATAW-1:DATAW] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed bench for fetch_queue at MEM_LAT 1 and 3
module tb_fetch_queue;

    localparam logic [31:0] BASE = 32'h01000000;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_ready = 1'b0;

    logic [31:0] a_imem_address, a_imem_data, a_dec_instr, a_dec_pc;
    logic        a_imem_enable, a_dec_valid;
    logic [2:0]  a_occupancy;
    logic [31:0] b_imem_address, b_imem_data, b_dec_instr, b_dec_pc;
    logic        b_imem_enable, b_dec_valid;
    logic [2:0]  b_occupancy;

    int errors = 0;
    int checks = 0;

    logic [31:0] a_exp = BASE, b_exp = BASE;
    logic [31:0] a_prev_pc = '0, b_prev_pc = '0;
    logic        a_hold = 1'b0, b_hold = 1'b0;

    logic [31:0] a_addr_q = '0;
    logic [31:0] b_addr_q [3];
    logic [2:0]  b_en_q = '0;

    always #5 clock = ~clock;

    fetch_queue #(.DATAW(32), .BASE_ADDR(BASE), .DEPTH(4), .MEM_LAT(1)) dut_a (
        .clock(clock), .reset(reset),
        .imem_address(a_imem_address), .imem_enable(a_imem_enable), .imem_data(a_imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_ready(dec_ready), .dec_valid(a_dec_valid), .dec_instr(a_dec_instr),
        .dec_pc(a_dec_pc), .occupancy(a_occupancy)
    );

    fetch_queue #(.DATAW(32), .BASE_ADDR(BASE), .DEPTH(4), .MEM_LAT(3)) dut_b (
        .clock(clock), .reset(reset),
        .imem_address(b_imem_address), .imem_enable(b_imem_enable), .imem_data(b_imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_ready(dec_ready), .dec_valid(b_dec_valid), .dec_instr(b_dec_instr),
        .dec_pc(b_dec_pc), .occupancy(b_occupancy)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return {addr[15:0], addr[31:16]} ^ 32'h00000013;
    endfunction

    // Instruction memory models: data for the address captured MEM_LAT edges earlier.
    always @(posedge clock) begin
        a_addr_q    <= a_imem_address;
        b_addr_q[0] <= b_imem_address;
        b_addr_q[1] <= b_addr_q[0];
        b_addr_q[2] <= b_addr_q[1];
        b_en_q      <= {b_en_q[1:0], b_imem_enable};
    end
    assign a_imem_data = instr_of(a_addr_q);
    assign b_imem_data = instr_of(b_addr_q[2]);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Apply inputs for the current cycle, score what decode sees, advance one clock.
    task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
        dec_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (!reset) begin
            if (a_dec_valid) begin
                check("a_pc", a_dec_pc, a_exp);
                check("a_instr", a_dec_instr, instr_of(a_dec_pc));
            end
            if (a_hold) begin
                check("a_hold_valid", 32'(a_dec_valid), 32'd1);
                check("a_hold_pc", a_dec_pc, a_prev_pc);
            end
            if (b_dec_valid) begin
                check("b_pc", b_dec_pc, b_exp);
                check("b_instr", b_dec_instr, instr_of(b_dec_pc));
            end
            if (b_hold) begin
                check("b_hold_valid", 32'(b_dec_valid), 32'd1);
                check("b_hold_pc", b_dec_pc, b_prev_pc);
            end
        end
        if (reset) begin
            a_exp = BASE;
            b_exp = BASE;
        end else if (redir) begin
            a_exp = rpc & 32'hFFFFFFFC;
            b_exp = rpc & 32'hFFFFFFFC;
        end else begin
            if (a_dec_valid && rdy) a_exp = a_exp + 32'd4;
            if (b_dec_valid && rdy) b_exp = b_exp + 32'd4;
        end
        a_hold    = !reset && !redir && a_dec_valid && !rdy;
        b_hold    = !reset && !redir && b_dec_valid && !rdy;
        a_prev_pc = a_dec_pc;
        b_prev_pc = b_dec_pc;
        @(posedge clock);
        #1;
    endtask

    task automatic reset_pulse(input int n);
        reset = 1'b1;
        repeat (n) cycle(1'b0, 1'b0, '0);
        check("rst_a_valid", 32'(a_dec_valid), 32'd0);
        check("rst_a_occ", 32'(a_occupancy), 32'd0);
        check("rst_a_en", 32'(a_imem_enable), 32'd0);
        check("rst_a_addr", a_imem_address, BASE);
        check("rst_a_instr", a_dec_instr, NOP);
        check("rst_a_pc", a_dec_pc, 32'd0);
        check("rst_b_valid", 32'(b_dec_valid), 32'd0);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        int found;
        @(posedge clock);
        #1;

        // Reset release, dec_ready high: cycle 0 is the first request cycle.
        reset_pulse(2);
        check("c0_en", 32'(a_imem_enable), 32'd1);
        check("c0_addr", a_imem_address, BASE);
        cycle(1'b1, 1'b0, '0);
        check("c1_a_valid", 32'(a_dec_valid), 32'd0);
        cycle(1'b1, 1'b0, '0);
        check("c2_a_valid", 32'(a_dec_valid), 32'd1);
        check("c2_a_pc", a_dec_pc, BASE);
        cycle(1'b1, 1'b0, '0);
        check("c3_a_pc", a_dec_pc, BASE + 32'd4);
        check("c3_b_valid", 32'(b_dec_valid), 32'd0);
        cycle(1'b1, 1'b0, '0);
        check("c4_a_pc", a_dec_pc, BASE + 32'd8);
        check("c4_b_valid", 32'(b_dec_valid), 32'd1);
        check("c4_b_pc", b_dec_pc, BASE);

        // Back-pressure: queue saturates and fetch stops, then drains in order.
        repeat (10) cycle(1'b0, 1'b0, '0);
        check("sat_a_occ", 32'(a_occupancy), 32'd4);
        check("sat_a_en", 32'(a_imem_enable), 32'd0);
        check("sat_b_occ", 32'(b_occupancy), 32'd4);
        check("sat_b_en", 32'(b_imem_enable), 32'd0);
        repeat (12) cycle(1'b1, 1'b0, '0);

        // Redirect with 3 queued and 1 in flight (MEM_LAT 1 instance).
        reset_pulse(1);
        repeat (4) cycle(1'b0, 1'b0, '0);
        check("pre_redir_a_occ", 32'(a_occupancy), 32'd3);
        check("pre_redir_a_en", 32'(a_imem_enable), 32'd0);
        cycle(1'b1, 1'b1, 32'h01000100);
        check("redir_a_occ", 32'(a_occupancy), 32'd0);
        check("redir_a_valid", 32'(a_dec_valid), 32'd0);
        cycle(1'b1, 1'b0, '0);
        check("redir_a_valid2", 32'(a_dec_valid), 32'd0);
        cycle(1'b1, 1'b0, '0);
        check("redir_a_pc", a_dec_pc, 32'h01000100);

        // MEM_LAT 3: redirect on a cycle with both a pop and a return.
        found = 0;
        for (int k = 0; k < 40; k++) begin
            if (b_dec_valid && b_en_q[2]) begin
                found = 1;
                break;
            end
            cycle(1'b1, 1'b0, '0);
        end
        check("b_pop_ret_seen", 32'(found), 32'd1);
        cycle(1'b1, 1'b1, 32'h01000200);
        check("redir_b_occ", 32'(b_occupancy), 32'd0);
        check("redir_b_valid", 32'(b_dec_valid), 32'd0);
        repeat (3) cycle(1'b1, 1'b0, '0);
        check("redir_b_valid_r4", 32'(b_dec_valid), 32'd0);
        cycle(1'b1, 1'b0, '0);
        check("redir_b_valid_r5", 32'(b_dec_valid), 32'd1);
        check("redir_b_pc", b_dec_pc, 32'h01000200);

        // Back-to-back redirects: last wins, low PC bits dropped.
        cycle(1'b1, 1'b1, 32'h01000300);
        cycle(1'b1, 1'b1, 32'h01000406);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        check("b2b_a_pc", a_dec_pc, 32'h01000404);

        // PC wraps modulo 2^32.
        cycle(1'b1, 1'b1, 32'hFFFFFFF8);
        repeat (8) cycle(1'b1, 1'b0, '0);

        // Reset mid-operation with a full queue and requests in flight.
        repeat (8) cycle(1'b0, 1'b0, '0);
        check("full_a_occ", 32'(a_occupancy), 32'd4);
        cycle(1'b1, 1'b1, 32'h01000500);
        repeat (2) cycle(1'b0, 1'b0, '0);
        reset_pulse(1);
        cycle(1'b1, 1'b0, '0);
        check("mrst_a_valid1", 32'(a_dec_valid), 32'd0);
        check("mrst_b_valid1", 32'(b_dec_valid), 32'd0);
        cycle(1'b1, 1'b0, '0);
        check("mrst_a_pc", a_dec_pc, BASE);
        check("mrst_b_valid2", 32'(b_dec_valid), 32'd0);
        cycle(1'b1, 1'b0, '0);
        check("mrst_b_valid3", 32'(b_dec_valid), 32'd0);
        cycle(1'b1, 1'b0, '0);
        check("mrst_b_pc", b_dec_pc, BASE);

        // Random back-pressure and redirects against the program-order model.
        for (int k = 0; k < 400; k++) begin
            logic rdy, redir;
            rdy   = ($urandom % 4) != 0;
            redir = ($urandom % 25) == 0;
            cycle(rdy, redir, $urandom);
        end
        repeat (6) cycle(1'b1, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
